// File: rtl/i2c_slave_pkg.sv
// ============================================================================
//  Module      : i2c_slave_pkg
//  Description : Shared definitions for the I2C target: FSM state encoding,
//                ACK/NACK and R/W bit values, bit-counter limits and the
//                address-compare helper.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

package i2c_slave_pkg;

  // Transaction phases of the target; the explicit values keep the encoding
  // stable across tools and visible in waveforms.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WRITE     = 3'd3,
    ST_WRITE_ACK = 3'd4,
    ST_READ      = 3'd5,
    ST_READ_ACK  = 3'd6,
    ST_WAIT_STOP = 3'd7
  } state_t;

  localparam logic I2C_ACK   = 1'b0;
  localparam logic I2C_NACK  = 1'b1;
  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

  // Bit counter limits: receive side counts 0..7, transmit side 1..8.
  localparam logic [3:0] LAST_BIT      = 4'd7;
  localparam logic [3:0] BITS_PER_BYTE = 4'd8;

  // True when the 7-bit address field of an address byte selects this target.
  function automatic logic addr_match(input logic [7:0] addr_byte,
                                      input logic [6:0] own_addr);
    return (addr_byte[7:1] == own_addr);
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_slave_line_sync.sv
// ============================================================================
//  Module      : i2c_slave_line_sync
//  Description : Two-flop synchronizers plus one history stage for SCL and
//                SDA. Produces registered one-cycle pulses for SCL rise/fall
//                and START/STOP, three clocks after the pin event.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module i2c_slave_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop,
  output logic o_sda
);

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_hist;
  logic       r_sda_hist;

  // Synchronize the bus lines and register edge/condition pulses; the lines
  // reset to the idle-bus level so no false edge appears after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_hist <= 1'b1;
      r_sda_hist <= 1'b1;
      o_scl_rise <= 1'b0;
      o_scl_fall <= 1'b0;
      o_start    <= 1'b0;
      o_stop     <= 1'b0;
    end else begin
      r_scl_sync <= {r_scl_sync[0], i_scl};
      r_sda_sync <= {r_sda_sync[0], i_sda};
      r_scl_hist <= r_scl_sync[1];
      r_sda_hist <= r_sda_sync[1];
      o_scl_rise <=  r_scl_sync[1] & ~r_scl_hist;
      o_scl_fall <= ~r_scl_sync[1] &  r_scl_hist;
      o_start    <=  r_scl_sync[1] &  r_scl_hist &  r_sda_hist & ~r_sda_sync[1];
      o_stop     <=  r_scl_sync[1] &  r_scl_hist & ~r_sda_hist &  r_sda_sync[1];
    end
  end

  // The history stage holds the SDA level the pulses above were derived from.
  assign o_sda = r_sda_hist;

endmodule

`default_nettype wire

// File: rtl/i2c_slave.sv
// ============================================================================
//  Module      : i2c_slave
//  Description : 7-bit-address I2C target. Oversamples SCL/SDA on the system
//                clock, delivers written bytes on a valid strobe and requests
//                read bytes with a request strobe. Never stretches SCL.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module i2c_slave #(
  parameter logic [6:0] ADDR = 7'h50
) (
  input  logic       iw_clk,
  input  logic       iw_reset,
  input  logic       iw_i2c_scl,
  inout  wire        io_i2c_sda,
  input  logic [7:0] iw_tx_data,
  output logic       or_tx_req,
  output logic [7:0] or_rx_data,
  output logic       or_rx_valid,
  output logic       or_rw,
  output logic       ow_busy
);

  import i2c_slave_pkg::*;

  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic       w_sda;
  logic [7:0] w_byte;

  state_t     r_state;
  logic [7:0] r_shift;
  logic [3:0] r_bit_cnt;
  logic       r_sda_oe;
  logic       r_ack_seen;
  logic       r_busy;

  i2c_slave_line_sync u_line_sync (
    .clk        (iw_clk),
    .rst_n      (iw_reset),
    .i_scl      (iw_i2c_scl),
    .i_sda      (io_i2c_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop),
    .o_sda      (w_sda)
  );

  // Byte as it stands once the bit sampled on this rise is shifted in.
  assign w_byte = {r_shift[6:0], w_sda};

  // Open-drain: only ever pull low or release.
  assign io_i2c_sda = r_sda_oe ? 1'b0 : 1'bz;
  assign ow_busy    = r_busy;

  // Protocol FSM; START/STOP override every state and any coincident SCL edge.
  always_ff @(posedge iw_clk) begin
    if (!iw_reset) begin
      r_state     <= ST_IDLE;
      r_shift     <= 8'h00;
      r_bit_cnt   <= 4'd0;
      r_sda_oe    <= 1'b0;
      r_ack_seen  <= 1'b0;
      r_busy      <= 1'b0;
      or_tx_req   <= 1'b0;
      or_rx_data  <= 8'h00;
      or_rx_valid <= 1'b0;
      or_rw       <= 1'b0;
    end else begin
      or_tx_req   <= 1'b0;
      or_rx_valid <= 1'b0;
      if (w_start) begin
        r_sda_oe   <= 1'b0;
        r_bit_cnt  <= 4'd0;
        r_ack_seen <= 1'b0;
        r_busy     <= 1'b0;
        r_state    <= ST_ADDR;
      end else if (w_stop) begin
        r_sda_oe   <= 1'b0;
        r_bit_cnt  <= 4'd0;
        r_ack_seen <= 1'b0;
        r_busy     <= 1'b0;
        r_state    <= ST_IDLE;
      end else begin
        case (r_state)
          ST_ADDR: begin
            if (w_scl_rise) begin
              r_shift <= w_byte;
              if (r_bit_cnt == LAST_BIT) begin
                r_bit_cnt <= 4'd0;
                if (addr_match(w_byte, ADDR)) begin
                  or_rw     <= w_byte[0];
                  or_tx_req <= (w_byte[0] == I2C_READ);
                  r_busy    <= 1'b1;
                  r_state   <= ST_ADDR_ACK;
                end else begin
                  r_state   <= ST_WAIT_STOP;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          // First fall starts the ACK, second fall ends it and starts data.
          ST_ADDR_ACK: begin
            if (w_scl_fall) begin
              if (!r_sda_oe) begin
                r_sda_oe <= 1'b1;
              end else if (or_rw == I2C_WRITE) begin
                r_sda_oe <= 1'b0;
                r_state  <= ST_WRITE;
              end else begin
                r_shift   <= iw_tx_data;
                r_sda_oe  <= ~iw_tx_data[7];
                r_bit_cnt <= 4'd1;
                r_state   <= ST_READ;
              end
            end
          end
          ST_WRITE: begin
            if (w_scl_rise) begin
              r_shift <= w_byte;
              if (r_bit_cnt == LAST_BIT) begin
                r_bit_cnt   <= 4'd0;
                or_rx_data  <= w_byte;
                or_rx_valid <= 1'b1;
                r_state     <= ST_WRITE_ACK;
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          ST_WRITE_ACK: begin
            if (w_scl_fall) begin
              if (!r_sda_oe) begin
                r_sda_oe <= 1'b1;
              end else begin
                r_sda_oe <= 1'b0;
                r_state  <= ST_WRITE;
              end
            end
          end
          // Bit 7 is already on the line; shift out 6..0, then release.
          ST_READ: begin
            if (w_scl_fall) begin
              if (r_bit_cnt == BITS_PER_BYTE) begin
                r_sda_oe   <= 1'b0;
                r_bit_cnt  <= 4'd0;
                r_ack_seen <= 1'b0;
                r_state    <= ST_READ_ACK;
              end else begin
                r_sda_oe  <= ~r_shift[6];
                r_shift   <= {r_shift[6:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          ST_READ_ACK: begin
            if (w_scl_rise) begin
              if (w_sda == I2C_ACK) begin
                or_tx_req  <= 1'b1;
                r_ack_seen <= 1'b1;
              end else if (w_sda == I2C_NACK) begin
                r_busy  <= 1'b0;
                r_state <= ST_WAIT_STOP;
              end
            end else if (w_scl_fall && r_ack_seen) begin
              r_shift    <= iw_tx_data;
              r_sda_oe   <= ~iw_tx_data[7];
              r_bit_cnt  <= 4'd1;
              r_ack_seen <= 1'b0;
              r_state    <= ST_READ;
            end
          end
          default: begin
            // IDLE and WAIT_STOP only leave on START/STOP.
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave.sv
// ============================================================================
//  Module      : tb_i2c_slave
//  Description : Self-checking bench for i2c_slave. A behavioural bus master
//                drives SCL/SDA; expected bytes, ACKs and strobe counts come
//                from the transaction-level rules of the target.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module tb_i2c_slave;

  import i2c_slave_pkg::*;

  localparam int         Q   = 5;      // quarter SCL period in clocks
  localparam logic [6:0] OWN = 7'h50;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       scl       = 1'b1;
  logic       m_sda_low = 1'b0;
  logic [7:0] tx_data   = 8'h00;
  logic       tx_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rw;
  logic       busy;
  wire        sda_bus;

  pullup (sda_bus);
  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

  i2c_slave #(.ADDR(OWN)) dut (
    .iw_clk      (clk),
    .iw_reset    (rst_n),
    .iw_i2c_scl  (scl),
    .io_i2c_sda  (sda_bus),
    .iw_tx_data  (tx_data),
    .or_tx_req   (tx_req),
    .or_rx_data  (rx_data),
    .or_rx_valid (rx_valid),
    .or_rw       (rw),
    .ow_busy     (busy)
  );

  initial forever #5 clk = ~clk;

  int         n_checks      = 0;
  int         n_fail        = 0;
  int         tx_req_cnt    = 0;
  int         slave_low_cnt = 0;
  int         tx_idx        = 0;
  logic [7:0] rx_got[$];
  logic [7:0] tx_q[$];

  // Observe strobes and bus ownership 2 time units after each rising edge;
  // supply the next queued read byte whenever a request appears.
  initial forever begin
    @(posedge clk);
    #2;
    if (rx_valid === 1'b1) rx_got.push_back(rx_data);
    if (sda_bus === 1'b0 && !m_sda_low) slave_low_cnt++;
    if (tx_req === 1'b1) begin
      tx_req_cnt++;
      if (tx_idx < tx_q.size()) begin
        tx_data = tx_q[tx_idx];
        tx_idx++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rx_at(input int idx);
    return (idx < rx_got.size()) ? {24'h0, rx_got[idx]} : 32'hDEAD_BEEF;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda_low = 1'b1;
    wait_clk(2*Q);
    scl = 1'b0;
  endtask

  task automatic clock_bit(input logic b, output logic s);
    wait_clk(Q);
    m_sda_low = ~b;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    s = sda_bus;
    wait_clk(Q);
    scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(Q);
    m_sda_low = 1'b1;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(2*Q);
    m_sda_low = 1'b0;
    wait_clk(2*Q);
  endtask

  task automatic bus_rstart();
    wait_clk(Q);
    m_sda_low = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(2*Q);
    m_sda_low = 1'b1;
    wait_clk(2*Q);
    scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic m_ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      b[i] = s;
    end
    clock_bit(m_ack, s);
  endtask

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] b;
    logic [7:0] v;
    logic [6:0] a;
    logic [7:0] exp_q[$];
    int         base_rx, base_req, base_low, nb;

    // ---- reset state ----
    rst_n = 1'b0;
    wait_clk(4);
    check("rst_sda", sda_bus, 1'b1);
    check("rst_tx_req", tx_req, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rw", rw, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    wait_clk(2*Q);

    // ---- write 0xAA to own address ----
    base_rx = rx_got.size();
    bus_start();
    send_byte({OWN, I2C_WRITE}, ack);
    check("wr_addr_ack", ack, I2C_ACK);
    check("wr_busy", busy, 1'b1);
    check("wr_rw", rw, I2C_WRITE);
    send_byte(8'hAA, ack);
    check("wr_data_ack", ack, I2C_ACK);
    bus_stop();
    check("wr_rx_count", rx_got.size() - base_rx, 1);
    check("wr_rx_data", rx_at(base_rx), 8'hAA);
    check("wr_busy_stop", busy, 1'b0);

    // ---- random multi-byte writes ----
    for (int t = 0; t < 3; t++) begin
      base_rx = rx_got.size();
      exp_q.delete();
      nb = $urandom_range(1, 3);
      bus_start();
      send_byte({OWN, I2C_WRITE}, ack);
      check("rw_addr_ack", ack, I2C_ACK);
      for (int k = 0; k < nb; k++) begin
        v = 8'($urandom);
        exp_q.push_back(v);
        send_byte(v, ack);
        check("rw_data_ack", ack, I2C_ACK);
      end
      bus_stop();
      check("rw_rx_count", rx_got.size() - base_rx, nb);
      for (int k = 0; k < nb; k++) check("rw_rx_data", rx_at(base_rx + k), exp_q[k]);
    end

    // ---- address mismatch: 0x51 then a random foreign address ----
    for (int t = 0; t < 2; t++) begin
      a = (t == 0) ? 7'h51 : 7'($urandom);
      if (a == OWN) a = a ^ 7'h01;
      base_rx  = rx_got.size();
      base_low = slave_low_cnt;
      bus_start();
      send_byte({a, I2C_WRITE}, ack);
      check("mm_addr_nack", ack, I2C_NACK);
      send_byte(8'h55, ack);
      check("mm_data_nack", ack, I2C_NACK);
      check("mm_busy", busy, 1'b0);
      bus_stop();
      check("mm_slave_drive", slave_low_cnt - base_low, 0);
      check("mm_rx_count", rx_got.size() - base_rx, 0);
      check("mm_state", 32'(dut.r_state), 32'(ST_IDLE));
    end

    // ---- two-byte read: 0x3C (ACK) then 0xC3 (NACK) ----
    tx_q.push_back(8'h3C);
    tx_q.push_back(8'hC3);
    base_req = tx_req_cnt;
    bus_start();
    send_byte({OWN, I2C_READ}, ack);
    check("rd_addr_ack", ack, I2C_ACK);
    check("rd_rw", rw, I2C_READ);
    recv_byte(I2C_ACK, b);
    check("rd_byte0", b, 8'h3C);
    recv_byte(I2C_NACK, b);
    check("rd_byte1", b, 8'hC3);
    check("rd_req_count", tx_req_cnt - base_req, 2);
    check("rd_state", 32'(dut.r_state), 32'(ST_WAIT_STOP));
    check("rd_busy", busy, 1'b0);
    bus_stop();

    // ---- random-length read ----
    nb = $urandom_range(1, 4);
    exp_q.delete();
    for (int k = 0; k < nb; k++) begin
      v = 8'($urandom);
      exp_q.push_back(v);
      tx_q.push_back(v);
    end
    base_req = tx_req_cnt;
    bus_start();
    send_byte({OWN, I2C_READ}, ack);
    check("rr_addr_ack", ack, I2C_ACK);
    for (int k = 0; k < nb; k++) begin
      recv_byte((k == nb - 1) ? I2C_NACK : I2C_ACK, b);
      check("rr_byte", b, exp_q[k]);
    end
    check("rr_req_count", tx_req_cnt - base_req, nb);
    bus_stop();

    // ---- write 0x12, repeated START, read ----
    base_rx = rx_got.size();
    v = 8'($urandom);
    tx_q.push_back(v);
    bus_start();
    send_byte({OWN, I2C_WRITE}, ack);
    check("rs_waddr_ack", ack, I2C_ACK);
    send_byte(8'h12, ack);
    check("rs_wdata_ack", ack, I2C_ACK);
    bus_rstart();
    check("rs_rx_count", rx_got.size() - base_rx, 1);
    check("rs_rx_data", rx_at(base_rx), 8'h12);
    send_byte({OWN, I2C_READ}, ack);
    check("rs_raddr_ack", ack, I2C_ACK);
    check("rs_rw", rw, I2C_READ);
    recv_byte(I2C_NACK, b);
    check("rs_rbyte", b, v);
    bus_stop();

    // ---- STOP after 4 data bits of a write ----
    base_rx = rx_got.size();
    v = 8'($urandom);
    bus_start();
    send_byte({OWN, I2C_WRITE}, ack);
    check("ps_addr_ack", ack, I2C_ACK);
    for (int i = 7; i >= 4; i--) clock_bit(v[i], s);
    bus_stop();
    wait_clk(2*Q);
    check("ps_rx_count", rx_got.size() - base_rx, 0);
    check("ps_state", 32'(dut.r_state), 32'(ST_IDLE));
    check("ps_sda", sda_bus, 1'b1);
    check("ps_busy", busy, 1'b0);

    // ---- reset while the target drives a 0 read bit ----
    v = 8'($urandom_range(0, 127));
    tx_q.push_back(v);
    bus_start();
    send_byte({OWN, I2C_READ}, ack);
    check("mr_addr_ack", ack, I2C_ACK);
    wait_clk(Q);
    check("mr_bit7_low", sda_bus, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mr_sda", sda_bus, 1'b1);
    check("mr_tx_req", tx_req, 1'b0);
    check("mr_rx_valid", rx_valid, 1'b0);
    check("mr_rx_data", rx_data, 8'h00);
    check("mr_rw", rw, 1'b0);
    check("mr_busy", busy, 1'b0);
    check("mr_state", 32'(dut.r_state), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    bus_stop();
    check("mr_idle_after", 32'(dut.r_state), 32'(ST_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- 7-bit-address I2C target (responder) that answers the transactions generated by i2c_master.
- Runs on a single fast system clock and oversamples SCL/SDA; never drives SCL (no clock stretching).
- Write transfers: received bytes are delivered on a one-cycle valid strobe.
- Read transfers: bytes are requested from the user logic with a one-cycle request strobe and shifted out on SDA.

Parameters:
- ADDR, 7'h50, own 7-bit slave address compared against the address byte.

Ports:
- iw_clk  input  1  system clock; every SCL high and low phase must last at least 4 iw_clk cycles.
- iw_reset  input  1  synchronous, active-low reset; all state is cleared on an iw_clk edge while low.
- iw_i2c_scl  input  1  bus SCL, resolved by pull-up.
- io_i2c_sda  inout  1  bus SDA, open-drain: this block drives 1'b0 or 1'bz, never 1'b1.
- iw_tx_data  input  8  byte to transmit on a read.
- or_tx_req  output  1  one-cycle pulse: iw_tx_data is needed.
- or_rx_data  output  8  last byte written by the master.
- or_rx_valid  output  1  one-cycle pulse: or_rx_data is updated.
- or_rw  output  1  R/W bit of the current transaction (1 = read).
- ow_busy  output  1  high from address ACK until STOP, repeated START or NACK completion.

Behaviour:
- Reset values: SDA released (z), or_tx_req=0, or_rx_valid=0, or_rx_data=8'h00, or_rw=0, ow_busy=0, state IDLE.
- Input path: SCL and SDA each pass through a 2-FF synchronizer plus one history register.
  - scl_rise, scl_fall: derived from synchronized SCL.
  - START: SDA 1->0 while SCL=1.
  - STOP: SDA 0->1 while SCL=1.
  - Detection latency is 3 iw_clk cycles after the pin event.
- Data sampling and SDA updates:
  - SDA is sampled only on scl_rise.
  - The SDA driver changes only on scl_fall, or immediately on START, STOP or reset.
- States and transitions:
  - IDLE: wait for START -> ADDR, bit counter = 0.
  - ADDR: shift 8 bits MSB first on scl_rise. After the 8th bit, if addr[7:1]==ADDR, latch or_rw=addr[0] -> ADDR_ACK; on mismatch -> WAIT_STOP.
  - ADDR_ACK: drive SDA low on the next scl_fall and hold it through the 9th SCL high; ow_busy=1. If or_rw=1, pulse or_tx_req on ADDR_ACK entry. Then:
    - write: release SDA on the following scl_fall -> WRITE.
    - read: at that scl_fall latch iw_tx_data into the shift register, drive bit7 -> READ.
  - WRITE: shift 8 bits on scl_rise. On the 8th rise, update or_rx_data and pulse or_rx_valid for 1 cycle -> WRITE_ACK.
  - WRITE_ACK: always ACK (drive low on scl_fall, release on the following scl_fall) -> WRITE.
  - READ: drive bits 6..0 on successive scl_falls. After the 8th bit, release SDA on scl_fall -> READ_ACK.
  - READ_ACK: sample SDA on scl_rise.
    - 0 (ACK): pulse or_tx_req; at the next scl_fall latch iw_tx_data and drive bit7 -> READ.
    - 1 (NACK): ow_busy=0 -> WAIT_STOP.
  - WAIT_STOP: SDA released; ignore bits until STOP or START.
- Global rules, highest priority, apply in any state:
  - START (including repeated START): release SDA, clear the counter -> ADDR.
  - STOP: release SDA, ow_busy=0 -> IDLE.
  - If START/STOP and a scl edge coincide, START/STOP wins.
  - A STOP or START in the middle of a WRITE byte discards the partial byte; no or_rx_valid.
- User timing contract: iw_tx_data must be stable from 1 cycle after or_tx_req until the next scl_fall (at least 3 cycles).
- Bit counter: 4 bits, wraps 0..8; it is never left at an undefined count after START.
- Reset in mid-operation: SDA is released at the first iw_clk edge with iw_reset=0, regardless of the bus phase.

Decomposition:
- Shared header i2c_defs.vh, holding:
  - state encodings (IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP);
  - I2C_ACK=1'b0 and I2C_NACK=1'b1;
  - I2C_WRITE=1'b0 and I2C_READ=1'b1.
  - i2c_master uses the same header.
- One sub-module, i2c_line_sync: synchronizers, history registers, scl_rise/scl_fall/start/stop pulses.

Test Plan:
- Write with matching address: master sends address 0x50 with W, then data 0xAA -> SDA low during both 9th bits; or_rx_valid pulses once with or_rx_data=0xAA; ow_busy falls after STOP.
- Address mismatch: master sends 0x51 with W, then 0x55 -> SDA never driven by the slave, no or_rx_valid; the block returns to IDLE on STOP.
- Two-byte read: address 0x50 with R, iw_tx_data=0x3C then 0xC3, master ACKs the first byte and NACKs the second -> SDA carries 0x3C then 0xC3 MSB first; or_tx_req pulses exactly twice; the block enters WAIT_STOP after the NACK.
- Repeated START: write 0x50 and 0x12, then a repeated START and a read of 0x50 -> or_rx_valid for 0x12, or_rw flips to 1, and the read proceeds normally.
- STOP inside a write byte, after 4 data bits -> no or_rx_valid; state IDLE; SDA released.
- iw_reset pulled low for 1 cycle while driving a read bit of 0 -> SDA is z on the next iw_clk edge and all outputs are at their reset values.
